// File: rtl/nd_2to1_pkg.sv
// Shared types and default sizes for the nd_2to1 merge node and its message FIFO.
package nd_2to1_pkg;

    localparam int NS_MESSAGE_FIFO_SIZE = 4;
    localparam int NS_ADDRESS_SIZE      = 4;
    localparam int NS_DATA_SIZE         = 8;
    localparam int NS_REDUN_SIZE        = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } out_state_t;

endpackage

// File: rtl/nd_msg_fifo.sv
// Circular message buffer shared by both inputs of the merge node.
// rd_msg always shows the entry at the tail; the clear input resets only the pointers and count.
module nd_msg_fifo
    import nd_2to1_pkg::*;
#(
    parameter int FSZ = NS_MESSAGE_FIFO_SIZE,
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE,
    localparam int MSZ = 2*ASZ + DSZ + RSZ,
    localparam int PW  = $clog2(FSZ)
) (
    input  logic           i_clk,
    input  logic           clr,
    input  logic           wr_en,
    input  logic [MSZ-1:0] wr_msg,
    input  logic           rd_en,
    output logic [MSZ-1:0] rd_msg,
    output logic           full,
    output logic           empty
);

    logic [MSZ-1:0] r_mem [FSZ];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [PW:0]    r_count;

    assign rd_msg = r_mem[r_tail];
    assign full   = (r_count == (PW+1)'(FSZ));
    assign empty  = (r_count == '0);

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            r_mem[r_head] <= wr_msg;
        end
    end

    // Pointers wrap naturally because FSZ is a power of two.
    always_ff @(posedge i_clk) begin
        if (clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (wr_en) begin
                r_head <= r_head + 1'b1;
            end
            if (rd_en) begin
                r_tail <= r_tail + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nd_2to1.sv
// Two-input merge node: round-robin accepts messages from rcv0/rcv1 into a shared FIFO
// and drains it in order onto snd0.
module nd_2to1
    import nd_2to1_pkg::*;
#(
    parameter int FSZ = NS_MESSAGE_FIFO_SIZE,
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack,
    output logic [1:0]     o_dbg_state
);

    localparam int MSZ = 2*ASZ + DSZ + RSZ;

    logic           r_ready;
    logic           r_rr_pri;
    logic           r_rcv0_ack;
    logic           r_rcv1_ack;
    logic           r_snd_req;
    logic [MSZ-1:0] r_snd_msg;
    out_state_t     r_state;

    logic           w_full;
    logic           w_empty;
    logic           w_elig0;
    logic           w_elig1;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_wr_en;
    logic           w_rd_en;
    logic           w_clr;
    logic [MSZ-1:0] w_wr_msg;
    logic [MSZ-1:0] w_rd_msg;

    // Four-phase channels: sender raises req with fields stable, receiver latches and raises
    // ack, sender drops req, receiver drops ack. An input is only re-accepted once its ack is low.
    assign w_elig0  = r_ready & rcv0_req & ~r_rcv0_ack & ~w_full;
    assign w_elig1  = r_ready & rcv1_req & ~r_rcv1_ack & ~w_full;
    assign w_gnt0   = w_elig0 & (~w_elig1 | ~r_rr_pri);
    assign w_gnt1   = w_elig1 & (~w_elig0 |  r_rr_pri);
    assign w_wr_en  = w_gnt0 | w_gnt1;
    assign w_wr_msg = w_gnt1 ? {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red}
                             : {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign w_rd_en  = r_ready & (r_state == ST_IDLE) & ~w_empty & ~snd0_ack;
    assign w_clr    = ~r_ready;

    nd_msg_fifo #(
        .FSZ (FSZ),
        .ASZ (ASZ),
        .DSZ (DSZ),
        .RSZ (RSZ)
    ) u_fifo (
        .i_clk  (i_clk),
        .clr    (w_clr),
        .wr_en  (w_wr_en),
        .wr_msg (w_wr_msg),
        .rd_en  (w_rd_en),
        .rd_msg (w_rd_msg),
        .full   (w_full),
        .empty  (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else if (!r_ready) begin
            r_ready    <= 1'b1;
            r_snd_req  <= 1'b0;
            r_rcv0_ack <= 1'b0;
            r_rcv1_ack <= 1'b0;
            r_snd_msg  <= '0;
            r_rr_pri   <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            if (w_gnt0) begin
                r_rcv0_ack <= 1'b1;
            end else if (!rcv0_req) begin
                r_rcv0_ack <= 1'b0;
            end
            if (w_gnt1) begin
                r_rcv1_ack <= 1'b1;
            end else if (!rcv1_req) begin
                r_rcv1_ack <= 1'b0;
            end
            if (w_gnt0) begin
                r_rr_pri <= 1'b1;
            end else if (w_gnt1) begin
                r_rr_pri <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rd_en) begin
                        r_snd_msg <= w_rd_msg;
                        r_snd_req <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (snd0_ack) begin
                        r_snd_req <= 1'b0;
                        r_state   <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!snd0_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready       = r_ready;
    assign snd0_req    = r_snd_req;
    assign rcv0_ack    = r_rcv0_ack;
    assign rcv1_ack    = r_rcv1_ack;
    assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = r_snd_msg;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nd_2to1.sv
// Bench for nd_2to1: scenario tasks drive the two input channels, a background consumer
// completes snd0 handshakes, and received messages are checked against an expected queue.
module tb_nd_2to1;

    localparam int FSZ = 4;
    localparam int ASZ = 4;
    localparam int DSZ = 8;
    localparam int RSZ = 4;
    localparam int MSZ = 2*ASZ + DSZ + RSZ;

    logic           i_clk;
    logic           reset;
    logic           ready;
    logic [ASZ-1:0] snd0_src, snd0_dst;
    logic [DSZ-1:0] snd0_dat;
    logic [RSZ-1:0] snd0_red;
    logic           snd0_req;
    logic           snd0_ack;
    logic [ASZ-1:0] rcv0_src, rcv0_dst, rcv1_src, rcv1_dst;
    logic [DSZ-1:0] rcv0_dat, rcv1_dat;
    logic [RSZ-1:0] rcv0_red, rcv1_red;
    logic           rcv0_req, rcv0_ack, rcv1_req, rcv1_ack;
    logic [1:0]     dbg_state;

    logic [MSZ-1:0] exp_q[$];
    logic [MSZ-1:0] got_q[$];
    int n_vec = 0;
    int n_err = 0;
    bit cons_en = 1'b0;
    int cons_dly_max = 0;

    nd_2to1 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
        .i_clk(i_clk), .reset(reset), .ready(ready),
        .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
        .snd0_req(snd0_req), .snd0_ack(snd0_ack),
        .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red),
        .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
        .rcv1_src(rcv1_src), .rcv1_dst(rcv1_dst), .rcv1_dat(rcv1_dat), .rcv1_red(rcv1_red),
        .rcv1_req(rcv1_req), .rcv1_ack(rcv1_ack),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Downstream consumer: captures each offered message, then acks after a random delay
    initial begin
        snd0_ack = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            if (cons_en && snd0_req && !snd0_ack) begin
                int dly;
                got_q.push_back({snd0_src, snd0_dst, snd0_dat, snd0_red});
                dly = $urandom_range(cons_dly_max, 0);
                for (int d = 0; d < dly; d++) begin
                    @(posedge i_clk); #1;
                end
                snd0_ack = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(posedge i_clk); #1;
                    if (!snd0_req) break;
                end
                snd0_ack = 1'b0;
            end
        end
    end

    function automatic logic [MSZ-1:0] pack(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                            input logic [DSZ-1:0] t, input logic [RSZ-1:0] r);
        return {s, d, t, r};
    endfunction

    function automatic logic [MSZ-1:0] rand_msg(input logic [DSZ-1:0] t);
        return pack(ASZ'($urandom_range(15, 0)), ASZ'($urandom_range(15, 0)), t,
                    RSZ'($urandom_range(15, 0)));
    endfunction

    function automatic logic get_ack(input int ch);
        return (ch == 0) ? rcv0_ack : rcv1_ack;
    endfunction

    // Driver tasks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic drive_req(input int ch, input logic [MSZ-1:0] m);
        if (ch == 0) begin
            {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
            rcv0_req = 1'b1;
        end else begin
            {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = m;
            rcv1_req = 1'b1;
        end
    endtask

    task automatic drop_req(input int ch);
        if (ch == 0) rcv0_req = 1'b0;
        else         rcv1_req = 1'b0;
    endtask

    // Raises req, waits up to max_wait cycles for ack; on ack completes the four phases.
    task automatic send_msg(input int ch, input logic [MSZ-1:0] m, input int max_wait,
                            output bit acked);
        acked = 1'b0;
        drive_req(ch, m);
        for (int i = 0; i < max_wait; i++) begin
            @(posedge i_clk); #1;
            if (get_ack(ch)) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) begin
            drop_req(ch);
            for (int i = 0; i < 4; i++) begin
                @(posedge i_clk); #1;
                if (!get_ack(ch)) break;
            end
        end
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_clk); #1;
        end
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_low: got %b, required 0", ready);
        end
        reset = 1'b0;
        idle(1);
        n_vec++;
        if (ready !== 1'b1 || snd0_req !== 1'b0 || rcv0_ack !== 1'b0 || rcv1_ack !== 1'b0 ||
            {snd0_src, snd0_dst, snd0_dat, snd0_red} !== '0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL init_outputs: ready=%b req=%b ack0=%b ack1=%b msg=%h st=%0d, required 1 0 0 0 0 0",
                     ready, snd0_req, rcv0_ack, rcv1_ack,
                     {snd0_src, snd0_dst, snd0_dat, snd0_red}, dbg_state);
        end
    endtask

    task automatic test_simultaneous(input int first);
        logic [MSZ-1:0] m0, m1, e, g;
        bit ok;
        m0 = rand_msg(8'h11);
        m1 = rand_msg(8'h22);
        if (first == 0) begin
            exp_q.push_back(m0); exp_q.push_back(m1);
        end else begin
            exp_q.push_back(m1); exp_q.push_back(m0);
        end
        drive_req(0, m0);
        drive_req(1, m1);
        idle(1);
        n_vec++;
        if (get_ack(first) !== 1'b1 || get_ack(1 - first) !== 1'b0) begin
            n_err++;
            $display("FAIL simul_first_grant: ack0=%b ack1=%b, required only ack%0d", rcv0_ack, rcv1_ack, first);
        end
        drop_req(first);
        idle(1);
        n_vec++;
        if (get_ack(1 - first) !== 1'b1 || get_ack(first) !== 1'b0) begin
            n_err++;
            $display("FAIL simul_second_grant: ack0=%b ack1=%b, required only ack%0d", rcv0_ack, rcv1_ack, 1 - first);
        end
        drop_req(1 - first);
        cons_dly_max = 0;
        cons_en = 1'b1;
        wait_got(2, 40, ok);
        cons_en = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL simul_drain_timeout: got %0d msgs, required 2", got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL simul_order: got nothing, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_err++; $display("FAIL simul_order: got %h, required %h", g, e);
                end
            end
        end
        idle(6);
    endtask

    task automatic test_single();
        logic [MSZ-1:0] m, e, g;
        bit ok, seen;
        m = pack(4'd1, 4'd5, 8'hA5, RSZ'($urandom_range(15, 0)));
        exp_q.push_back(m);
        drive_req(0, m);
        idle(1);
        n_vec++;
        if (rcv0_ack !== 1'b1) begin
            n_err++; $display("FAIL single_ack_latency: got %b, required 1", rcv0_ack);
        end
        drop_req(0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (snd0_req) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen || snd0_dst !== 4'd5 || snd0_dat !== 8'hA5 || snd0_src !== 4'd1) begin
            n_err++;
            $display("FAIL single_output: req=%b src=%h dst=%h dat=%h, required 1 1 5 a5",
                     snd0_req, snd0_src, snd0_dst, snd0_dat);
        end
        cons_dly_max = 0;
        cons_en = 1'b1;
        wait_got(1, 20, ok);
        cons_en = 1'b0;
        idle(5);
        n_vec++;
        if (!ok || snd0_req !== 1'b0 || rcv0_ack !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL single_complete: got=%0d req=%b ack0=%b st=%0d, required 1 0 0 0",
                     got_q.size(), snd0_req, rcv0_ack, dbg_state);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL single_msg: got nothing, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_err++; $display("FAIL single_msg: got %h, required %h", g, e);
                end
            end
        end
    endtask

    // With snd0_ack held low, one message sits in the output register and FSZ fill the FIFO.
    task automatic test_backpressure();
        logic [MSZ-1:0] m, e, g;
        bit acked, ok;
        int n_acked, pend_ch;
        n_acked = 0;
        pend_ch = 0;
        cons_en = 1'b0;
        for (int k = 0; k < FSZ + 2; k++) begin
            m = rand_msg(DSZ'(8'h40 + k));
            exp_q.push_back(m);
            send_msg(k % 2, m, 6, acked);
            if (acked) n_acked++;
            else       pend_ch = k % 2;
        end
        n_vec++;
        if (n_acked != FSZ + 1) begin
            n_err++; $display("FAIL full_ack_count: got %0d acks, required %0d", n_acked, FSZ + 1);
        end
        idle(4);
        n_vec++;
        if (get_ack(pend_ch) !== 1'b0 || snd0_req !== 1'b1) begin
            n_err++;
            $display("FAIL full_hold: pending ack=%b snd0_req=%b, required 0 1", get_ack(pend_ch), snd0_req);
        end
        cons_dly_max = 0;
        cons_en = 1'b1;
        wait_got(1, 20, ok);
        cons_en = 1'b0;
        acked = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (get_ack(pend_ch)) begin
                acked = 1'b1;
                break;
            end
            idle(1);
        end
        n_vec++;
        if (!ok || !acked) begin
            n_err++; $display("FAIL full_release: transfer=%b pending_acked=%b, required 1 1", ok, acked);
        end
        drop_req(pend_ch);
        idle(2);
        cons_en = 1'b1;
        wait_got(FSZ + 2, 200, ok);
        cons_en = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL full_drain_timeout: got %0d msgs, required %0d", got_q.size(), FSZ + 2);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL full_order: got nothing, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_err++; $display("FAIL full_order: got %h, required %h", g, e);
                end
            end
        end
        idle(6);
    endtask

    task automatic test_wrap();
        logic [MSZ-1:0] m, e, g;
        bit acked, ok;
        int n_lost;
        n_lost = 0;
        cons_dly_max = 3;
        cons_en = 1'b1;
        for (int i = 0; i < 3 * FSZ; i++) begin
            int ch;
            ch = $urandom_range(1, 0);
            m = rand_msg(DSZ'(i));
            exp_q.push_back(m);
            send_msg(ch, m, 40, acked);
            if (!acked) begin
                n_lost++;
                drop_req(ch);
                idle(2);
            end
        end
        n_vec++;
        if (n_lost != 0) begin
            n_err++; $display("FAIL wrap_acks: got %0d unacked sends, required 0", n_lost);
        end
        wait_got(3 * FSZ, 400, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL wrap_drain_timeout: got %0d msgs, required %0d", got_q.size(), 3 * FSZ);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL wrap_order: got nothing, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_err++; $display("FAIL wrap_order: got %h, required %h", g, e);
                end
            end
        end
        idle(12);
        cons_en = 1'b0;
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++; $display("FAIL wrap_duplicates: got %0d extra msgs, required 0", got_q.size());
            got_q.delete();
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        logic [MSZ-1:0] m, e, g;
        bit acked, ok;
        cons_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_msg(k % 2, rand_msg(DSZ'(8'h80 + k)), 6, acked);
        end
        n_vec++;
        if (snd0_req !== 1'b1) begin
            n_err++; $display("FAIL midreset_setup: snd0_req=%b, required 1", snd0_req);
        end
        reset = 1'b1;
        idle(1);
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL midreset_ready_drop: got %b, required 0", ready);
        end
        idle(1);
        reset = 1'b0;
        idle(1);
        n_vec++;
        if (ready !== 1'b1 || snd0_req !== 1'b0 || rcv0_ack !== 1'b0 || rcv1_ack !== 1'b0 ||
            snd0_dat !== '0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_init: ready=%b req=%b ack0=%b ack1=%b dat=%h st=%0d, required 1 0 0 0 0 0",
                     ready, snd0_req, rcv0_ack, rcv1_ack, snd0_dat, dbg_state);
        end
        exp_q.delete();
        got_q.delete();
        idle(4);
        n_vec++;
        if (snd0_req !== 1'b0) begin
            n_err++; $display("FAIL midreset_empty: snd0_req=%b, required 0", snd0_req);
        end
        cons_dly_max = 1;
        cons_en = 1'b1;
        m = rand_msg(8'h5C);
        exp_q.push_back(m);
        send_msg(1, m, 6, acked);
        wait_got(1, 30, ok);
        idle(12);
        cons_en = 1'b0;
        n_vec++;
        if (!acked || !ok || got_q.size() != 1) begin
            n_err++;
            $display("FAIL midreset_new_msg: acked=%b msgs=%0d, required 1 1", acked, got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL midreset_msg: got nothing, required %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_err++; $display("FAIL midreset_msg: got %h, required %h", g, e);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rcv0_req = 1'b0; rcv1_req = 1'b0;
        {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = '0;
        {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = '0;
        @(posedge i_clk); #1;
        test_reset();
        test_simultaneous(0);
        test_single();
        test_simultaneous(1);
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
